// File: rtl/dispatch_tag_stage.sv
// Dispatch tag stage: takes a 4-wide decoded group from the instruction buffer,
// gives each branch a control tag from a free bitmap, and registers the group for rename.
module dispatch_tag_stage #(
    parameter int PKT_W    = 64,
    parameter int BR_BIT   = 50,
    parameter int NUM_TAGS = 8,
    parameter int TAG_LOG  = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_i,
    input  logic               instBufferReady_i,
    input  logic [PKT_W-1:0]   decodedPacket0_i,
    input  logic [PKT_W-1:0]   decodedPacket1_i,
    input  logic [PKT_W-1:0]   decodedPacket2_i,
    input  logic [PKT_W-1:0]   decodedPacket3_i,
    input  logic [2:0]         branchCount_i,
    input  logic               stall_i,
    input  logic               resolveValid_i,
    input  logic [TAG_LOG-1:0] resolveTag_i,
    output logic               stallBuffer_o,
    output logic               valid_o,
    output logic [PKT_W-1:0]   decodedPacket0_o,
    output logic [PKT_W-1:0]   decodedPacket1_o,
    output logic [PKT_W-1:0]   decodedPacket2_o,
    output logic [PKT_W-1:0]   decodedPacket3_o,
    output logic [TAG_LOG-1:0] tag0_o,
    output logic [TAG_LOG-1:0] tag1_o,
    output logic [TAG_LOG-1:0] tag2_o,
    output logic [TAG_LOG-1:0] tag3_o,
    output logic [3:0]         tagValid_o,
    output logic [TAG_LOG:0]   freeCount_o
);

    localparam int SLOTS = 4;

    typedef logic [PKT_W-1:0]   pkt_t;
    typedef logic [TAG_LOG-1:0] tag_t;

    pkt_t                pktIn [SLOTS];
    logic [NUM_TAGS-1:0] freeVec_q, freeVec_d;
    logic                valid_q, valid_d;
    pkt_t                pkt_q [SLOTS];
    pkt_t                pkt_d [SLOTS];
    tag_t                tag_q [SLOTS];
    tag_t                tag_d [SLOTS];
    logic [SLOTS-1:0]    tagv_q, tagv_d;

    tag_t                allocTag [SLOTS];
    logic [SLOTS-1:0]    allocValid;
    logic [NUM_TAGS-1:0] allocMask;
    logic [NUM_TAGS-1:0] avail;
    logic                found;
    logic [TAG_LOG:0]    freeCount;
    logic                hold, noTag, stallBuf, accept;

    assign pktIn[0] = decodedPacket0_i;
    assign pktIn[1] = decodedPacket1_i;
    assign pktIn[2] = decodedPacket2_i;
    assign pktIn[3] = decodedPacket3_i;

    always_comb begin
        freeCount = '0;
        for (int t = 0; t < NUM_TAGS; t++)
            freeCount = freeCount + (TAG_LOG+1)'(freeVec_q[t]);
    end

    // Oldest slot first, each branch takes the lowest tag still free this cycle.
    always_comb begin
        avail      = freeVec_q;
        allocMask  = '0;
        allocValid = '0;
        found      = 1'b0;
        for (int s = 0; s < SLOTS; s++) begin
            allocTag[s] = '0;
            found       = 1'b0;
            if (pktIn[s][BR_BIT]) begin
                for (int t = 0; t < NUM_TAGS; t++) begin
                    if (!found && avail[t]) begin
                        found         = 1'b1;
                        avail[t]      = 1'b0;
                        allocMask[t]  = 1'b1;
                        allocTag[s]   = TAG_LOG'(t);
                        allocValid[s] = 1'b1;
                    end
                end
            end
        end
    end

    assign hold     = valid_q & stall_i;
    assign noTag    = instBufferReady_i & (int'(branchCount_i) > int'(freeCount));
    assign stallBuf = ~flush_i & (hold | noTag);
    assign accept   = ~flush_i & instBufferReady_i & ~stallBuf;

    always_comb begin
        freeVec_d = freeVec_q;
        if (flush_i) begin
            freeVec_d = '1;
        end else begin
            if (accept)
                freeVec_d = freeVec_d & ~allocMask;
            if (resolveValid_i)
                freeVec_d[resolveTag_i] = 1'b1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        tag_d   = tag_q;
        tagv_d  = tagv_q;
        if (flush_i) begin
            valid_d = 1'b0;
            tagv_d  = '0;
        end else if (hold) begin
            valid_d = valid_q;
        end else if (accept) begin
            valid_d = 1'b1;
            pkt_d   = pktIn;
            tag_d   = allocTag;
            tagv_d  = allocValid;
        end else begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            freeVec_q <= '1;
            valid_q   <= 1'b0;
            tagv_q    <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                pkt_q[s] <= '0;
                tag_q[s] <= '0;
            end
        end else begin
            freeVec_q <= freeVec_d;
            valid_q   <= valid_d;
            pkt_q     <= pkt_d;
            tag_q     <= tag_d;
            tagv_q    <= tagv_d;
        end
    end

    assign stallBuffer_o    = stallBuf;
    assign valid_o          = valid_q;
    assign decodedPacket0_o = pkt_q[0];
    assign decodedPacket1_o = pkt_q[1];
    assign decodedPacket2_o = pkt_q[2];
    assign decodedPacket3_o = pkt_q[3];
    assign tag0_o           = tag_q[0];
    assign tag1_o           = tag_q[1];
    assign tag2_o           = tag_q[2];
    assign tag3_o           = tag_q[3];
    assign tagValid_o       = tagv_q;
    assign freeCount_o      = freeCount;

endmodule

// File: tb/tb_dispatch_tag_stage.sv
// Directed bench for dispatch_tag_stage: allocation order, tag shortage stall,
// downstream hold, flush, back-to-back groups and reset.
module tb_dispatch_tag_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush_i;
    logic        instBufferReady_i;
    logic [63:0] pin0, pin1, pin2, pin3;
    logic [2:0]  branchCount_i;
    logic        stall_i;
    logic        resolveValid_i;
    logic [2:0]  resolveTag_i;
    logic        stallBuffer_o;
    logic        valid_o;
    logic [63:0] pout0, pout1, pout2, pout3;
    logic [2:0]  tag0_o, tag1_o, tag2_o, tag3_o;
    logic [3:0]  tagValid_o;
    logic [3:0]  freeCount_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dispatch_tag_stage dut (
        .clk(clk), .reset(reset), .flush_i(flush_i),
        .instBufferReady_i(instBufferReady_i),
        .decodedPacket0_i(pin0), .decodedPacket1_i(pin1),
        .decodedPacket2_i(pin2), .decodedPacket3_i(pin3),
        .branchCount_i(branchCount_i), .stall_i(stall_i),
        .resolveValid_i(resolveValid_i), .resolveTag_i(resolveTag_i),
        .stallBuffer_o(stallBuffer_o), .valid_o(valid_o),
        .decodedPacket0_o(pout0), .decodedPacket1_o(pout1),
        .decodedPacket2_o(pout2), .decodedPacket3_o(pout3),
        .tag0_o(tag0_o), .tag1_o(tag1_o), .tag2_o(tag2_o), .tag3_o(tag3_o),
        .tagValid_o(tagValid_o), .freeCount_o(freeCount_o)
    );

    function automatic logic [63:0] mk(input int id, input logic br);
        logic [63:0] p;
        p = {8'h5A, 56'(id)};
        p[50] = br;
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Branch mask m, packet ids id..id+3; branch count derived from the mask.
    task automatic grp(input logic [3:0] m, input int id);
        pin0 = mk(id,   m[0]);
        pin1 = mk(id+1, m[1]);
        pin2 = mk(id+2, m[2]);
        pin3 = mk(id+3, m[3]);
        branchCount_i = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
        instBufferReady_i = 1'b1;
    endtask

    task automatic do_flush();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; flush_i = 0; instBufferReady_i = 0; stall_i = 0;
        resolveValid_i = 0; resolveTag_i = 0; branchCount_i = 0;
        pin0 = 0; pin1 = 0; pin2 = 0; pin3 = 0;
        tick(); tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0h expected 0", valid_o); end
        checks++; if (tagValid_o !== 4'b0) begin errors++; $display("FAIL reset_tagValid: got %0h expected 0", tagValid_o); end
        checks++; if (freeCount_o !== 4'd8) begin errors++; $display("FAIL reset_freeCount: got %0d expected 8", freeCount_o); end
        checks++; if ({tag0_o, tag1_o, tag2_o, tag3_o} !== 12'h0) begin errors++; $display("FAIL reset_tags: got %0h expected 0", {tag0_o, tag1_o, tag2_o, tag3_o}); end
        checks++; if (pout3 !== 64'h0) begin errors++; $display("FAIL reset_packet3: got %0h expected 0", pout3); end
        checks++; if (stallBuffer_o !== 1'b0) begin errors++; $display("FAIL reset_stallBuffer: got %0h expected 0", stallBuffer_o); end
    endtask

    task automatic test_basic();
        reset = 1'b1;
        grp(4'b1010, 'h10);
        #1;
        checks++; if (stallBuffer_o !== 1'b0) begin errors++; $display("FAIL basic_stall: got %0h expected 0", stallBuffer_o); end
        tick();
        instBufferReady_i = 0;
        #1;
        checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL basic_valid: got %0h expected 1", valid_o); end
        checks++; if (tag1_o !== 3'd0 || tag3_o !== 3'd1) begin errors++; $display("FAIL basic_tags: got tag1=%0d tag3=%0d expected 0,1", tag1_o, tag3_o); end
        checks++; if (tagValid_o !== 4'b1010) begin errors++; $display("FAIL basic_tagValid: got %b expected 1010", tagValid_o); end
        checks++; if (freeCount_o !== 4'd6) begin errors++; $display("FAIL basic_freeCount: got %0d expected 6", freeCount_o); end
        checks++; if (pout1 !== mk('h11, 1'b1)) begin errors++; $display("FAIL basic_packet1: got %0h expected %0h", pout1, mk('h11, 1'b1)); end
        tick();
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL basic_idle_valid: got %0h expected 0", valid_o); end
    endtask

    // Build tags 0..3,5,6 in use (4,7 free), then a 3-branch group must wait.
    task automatic test_notag();
        do_flush();
        grp(4'b1111, 'h20); tick();
        grp(4'b0111, 'h30); tick();
        instBufferReady_i = 0;
        resolveValid_i = 1; resolveTag_i = 3'd4;
        tick();
        resolveValid_i = 0;
        #1;
        checks++; if (freeCount_o !== 4'd2) begin errors++; $display("FAIL notag_setup_free: got %0d expected 2", freeCount_o); end
        grp(4'b1101, 'h40);
        resolveValid_i = 1; resolveTag_i = 3'd6;
        #1;
        checks++; if (stallBuffer_o !== 1'b1) begin errors++; $display("FAIL notag_stall: got %0h expected 1", stallBuffer_o); end
        tick();
        resolveValid_i = 0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL notag_valid: got %0h expected 0", valid_o); end
        checks++; if (freeCount_o !== 4'd3) begin errors++; $display("FAIL notag_free_after_resolve: got %0d expected 3", freeCount_o); end
        checks++; if (stallBuffer_o !== 1'b0) begin errors++; $display("FAIL notag_unstall: got %0h expected 0", stallBuffer_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || tagValid_o !== 4'b1101) begin errors++; $display("FAIL notag_accept: got valid=%0h tv=%b expected 1 1101", valid_o, tagValid_o); end
        checks++; if (tag0_o !== 3'd4 || tag2_o !== 3'd6 || tag3_o !== 3'd7) begin errors++; $display("FAIL notag_tags: got %0d %0d %0d expected 4 6 7", tag0_o, tag2_o, tag3_o); end
        checks++; if (freeCount_o !== 4'd0) begin errors++; $display("FAIL notag_free_zero: got %0d expected 0", freeCount_o); end
    endtask

    // Outputs hold under stall; then a zero-branch group goes through with no free tags.
    task automatic test_hold();
        stall_i = 1;
        grp(4'b0000, 'h50);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (stallBuffer_o !== 1'b1) begin errors++; $display("FAIL hold_stall%0d: got %0h expected 1", i, stallBuffer_o); end
            tick();
            checks++; if (valid_o !== 1'b1 || pout0 !== mk('h40, 1'b1) || tag3_o !== 3'd7 || freeCount_o !== 4'd0)
                begin errors++; $display("FAIL hold_outputs%0d: got v=%0h p0=%0h t3=%0d fc=%0d expected 1 %0h 7 0", i, valid_o, pout0, tag3_o, freeCount_o, mk('h40, 1'b1)); end
        end
        stall_i = 0;
        #1;
        checks++; if (stallBuffer_o !== 1'b0) begin errors++; $display("FAIL hold_release_stall: got %0h expected 0", stallBuffer_o); end
        tick();
        instBufferReady_i = 0;
        #1;
        checks++; if (valid_o !== 1'b1 || pout0 !== mk('h50, 1'b0) || tagValid_o !== 4'b0 || tag3_o !== 3'd0)
            begin errors++; $display("FAIL hold_zero_branch: got v=%0h p0=%0h tv=%b t3=%0d expected 1 %0h 0000 0", valid_o, pout0, tagValid_o, tag3_o, mk('h50, 1'b0)); end
    endtask

    task automatic test_flush();
        do_flush();
        grp(4'b1111, 'h60); tick();
        grp(4'b0001, 'h70); tick();
        stall_i = 1;
        grp(4'b0011, 'h80);
        #1;
        checks++; if (stallBuffer_o !== 1'b1 || freeCount_o !== 4'd3) begin errors++; $display("FAIL flush_pre: got stall=%0h fc=%0d expected 1 3", stallBuffer_o, freeCount_o); end
        flush_i = 1; resolveValid_i = 1; resolveTag_i = 3'd0;
        #1;
        checks++; if (stallBuffer_o !== 1'b0) begin errors++; $display("FAIL flush_stall: got %0h expected 0", stallBuffer_o); end
        tick();
        flush_i = 0; resolveValid_i = 0; instBufferReady_i = 0; stall_i = 0;
        #1;
        checks++; if (valid_o !== 1'b0 || freeCount_o !== 4'd8 || tagValid_o !== 4'b0)
            begin errors++; $display("FAIL flush_after: got v=%0h fc=%0d tv=%b expected 0 8 0000", valid_o, freeCount_o, tagValid_o); end
    endtask

    task automatic test_back_to_back();
        grp(4'b1111, 'h90); tick();
        grp(4'b1111, 'hA0);
        #1;
        checks++; if (valid_o !== 1'b1 || tag0_o !== 3'd0 || tag3_o !== 3'd3 || freeCount_o !== 4'd4)
            begin errors++; $display("FAIL b2b_first: got v=%0h t0=%0d t3=%0d fc=%0d expected 1 0 3 4", valid_o, tag0_o, tag3_o, freeCount_o); end
        tick();
        grp(4'b1111, 'hB0);
        #1;
        checks++; if (tag0_o !== 3'd4 || tag1_o !== 3'd5 || tag3_o !== 3'd7 || pout2 !== mk('hA2, 1'b1))
            begin errors++; $display("FAIL b2b_second: got t0=%0d t1=%0d t3=%0d p2=%0h expected 4 5 7 %0h", tag0_o, tag1_o, tag3_o, pout2, mk('hA2, 1'b1)); end
        checks++; if (freeCount_o !== 4'd0 || stallBuffer_o !== 1'b1) begin errors++; $display("FAIL b2b_third_stall: got fc=%0d stall=%0h expected 0 1", freeCount_o, stallBuffer_o); end
        tick();
        instBufferReady_i = 0;
        #1;
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL b2b_third_valid: got %0h expected 0", valid_o); end
    endtask

    task automatic test_resolve_free_and_reset();
        do_flush();
        resolveValid_i = 1; resolveTag_i = 3'd2;
        tick();
        resolveValid_i = 0;
        #1;
        checks++; if (freeCount_o !== 4'd8) begin errors++; $display("FAIL resolve_free: got %0d expected 8", freeCount_o); end
        grp(4'b0100, 'hC0); tick();
        stall_i = 1; instBufferReady_i = 0;
        tick();
        checks++; if (valid_o !== 1'b1 || tagValid_o !== 4'b0100 || freeCount_o !== 4'd7)
            begin errors++; $display("FAIL midhold_pre: got v=%0h tv=%b fc=%0d expected 1 0100 7", valid_o, tagValid_o, freeCount_o); end
        reset = 0;
        tick();
        reset = 1; stall_i = 0;
        #1;
        checks++; if (valid_o !== 1'b0 || tagValid_o !== 4'b0 || freeCount_o !== 4'd8 || tag2_o !== 3'd0 || pout2 !== 64'h0)
            begin errors++; $display("FAIL midhold_reset: got v=%0h tv=%b fc=%0d t2=%0d p2=%0h expected 0 0000 8 0 0", valid_o, tagValid_o, freeCount_o, tag2_o, pout2); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_notag();
        test_hold();
        test_flush();
        test_back_to_back();
        test_resolve_free_and_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
